// File: rtl/clock_route_path_sel_ctrl_if.sv
// Request and status bundle between the power/software controller and the
// clock route path selector sequencer.
interface clock_route_path_sel_ctrl_if;
   logic path_en;
   logic path_sel;
   logic control_path_enable0;
   logic control_path_enable1;
   logic active_path;
   logic switch_busy;
   logic switch_done;

   modport master (
      output path_en,
      output path_sel,
      input  control_path_enable0,
      input  control_path_enable1,
      input  active_path,
      input  switch_busy,
      input  switch_done
   );

   modport slave (
      input  path_en,
      input  path_sel,
      output control_path_enable0,
      output control_path_enable1,
      output active_path,
      output switch_busy,
      output switch_done
   );
endinterface

// File: rtl/clock_route_path_sel_ctrl.sv
// Break-before-make sequencer for a two-input clock mux: both gate enables are
// held low for OFF_CYCLES before either rises, and they are never high together.
module clock_route_path_sel_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int OFF_CYCLES  = 4,
   parameter int ON_CYCLES   = 2
) (
   input logic                        clk,
   input logic                        rst,
   clock_route_path_sel_ctrl_if.slave bus
);

   localparam int MAX_CYCLES = (OFF_CYCLES > ON_CYCLES) ? OFF_CYCLES : ON_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_DRAIN,
      ST_SETTLE,
      ST_ON
   } state_t;

   logic [SYNC_STAGES-1:0] en_sync;
   logic [SYNC_STAGES-1:0] sel_sync;
   logic                   path_en_s;
   logic                   path_sel_s;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             tgt;
   logic             enable0;
   logic             enable1;
   logic             active;
   logic             busy;
   logic             done;

   // Requests are asynchronous levels; only the last stage is ever used.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_sync  <= '0;
         sel_sync <= '0;
      end else begin
         // NOTE: non-blocking assignments make each stage take the previous
         // stage's old value, which is what turns this into a shift chain.
         en_sync  <= {en_sync[SYNC_STAGES-2:0], bus.path_en};
         sel_sync <= {sel_sync[SYNC_STAGES-2:0], bus.path_sel};
      end
   end

   assign path_en_s  = en_sync[SYNC_STAGES-1];
   assign path_sel_s = sel_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_OFF;
         cnt     <= '0;
         tgt     <= 1'b0;
         enable0 <= 1'b0;
         enable1 <= 1'b0;
         active  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         // Losing the request overrides any sequence in flight, without a done pulse.
         if (!path_en_s) begin
            state   <= ST_OFF;
            cnt     <= '0;
            enable0 <= 1'b0;
            enable1 <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               ST_OFF: begin
                  tgt   <= path_sel_s;
                  cnt   <= OFF_LOAD;
                  busy  <= 1'b1;
                  state <= ST_DRAIN;
               end
               ST_DRAIN: begin
                  if (cnt == '0) begin
                     enable0 <= ~tgt;
                     enable1 <= tgt;
                     active  <= tgt;
                     cnt     <= ON_LOAD;
                     state   <= ST_SETTLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_SETTLE: begin
                  if (cnt == '0) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_ON;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_ON: begin
                  // Select is only looked at here, so the latest value always wins.
                  if (path_sel_s != active) begin
                     enable0 <= 1'b0;
                     enable1 <= 1'b0;
                     tgt     <= path_sel_s;
                     cnt     <= OFF_LOAD;
                     busy    <= 1'b1;
                     state   <= ST_DRAIN;
                  end
               end
               default: state <= ST_OFF;
            endcase
         end
      end
   end

   assign bus.control_path_enable0 = enable0;
   assign bus.control_path_enable1 = enable1;
   assign bus.active_path          = active;
   assign bus.switch_busy          = busy;
   assign bus.switch_done          = done;

endmodule

// File: tb/tb_clock_route_path_sel_ctrl.sv
// Directed vectors on a default-parameter instance plus a randomized run on a
// fast (OFF=1, ON=1, SYNC=3) instance, both watched by invariant monitors.
module tb_clock_route_path_sel_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   clock_route_path_sel_ctrl_if bus_a ();
   clock_route_path_sel_ctrl_if bus_b ();

   clock_route_path_sel_ctrl #(
      .SYNC_STAGES(2), .OFF_CYCLES(4), .ON_CYCLES(2)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave)
   );

   clock_route_path_sel_ctrl #(
      .SYNC_STAGES(3), .OFF_CYCLES(1), .ON_CYCLES(1)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // {enable0, enable1, active_path, switch_busy, switch_done}
   function automatic logic [31:0] outs_a();
      return 32'({bus_a.control_path_enable0, bus_a.control_path_enable1,
                  bus_a.active_path, bus_a.switch_busy, bus_a.switch_done});
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      name;
      logic       en;
      logic       sel;
      int         adv;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus_a.path_en  = vecs[i].en;
         bus_a.path_sel = vecs[i].sel;
         step(vecs[i].adv);
         check(vecs[i].name, outs_a(), 32'(vecs[i].exp));
      end
   endtask

   // Invariant monitors for both instances, sampled on the falling edge.
   int         off_c [2] = '{4, 1};
   int         on_c  [2] = '{2, 1};
   int         low_run [2] = '{0, 0};
   int         since [2] = '{100, 100};
   logic [1:0] p0 = 2'b00;
   logic [1:0] p1 = 2'b00;

   always @(negedge clk) begin
      logic [1:0] e0, e1, dn;
      logic       rise;
      e0 = {bus_b.control_path_enable0, bus_a.control_path_enable0};
      e1 = {bus_b.control_path_enable1, bus_a.control_path_enable1};
      dn = {bus_b.switch_done, bus_a.switch_done};
      for (int k = 0; k < 2; k++) begin
         rise = (e0[k] & ~p0[k]) | (e1[k] & ~p1[k]);
         check($sformatf("exclusive_%0d", k), 32'(e0[k] & e1[k]), 0);
         if (rise)
            check($sformatf("dead_time_%0d", k), 32'(low_run[k] >= off_c[k]), 1);
         since[k] = rise ? 0 : ((since[k] < 100) ? since[k] + 1 : since[k]);
         if (since[k] == on_c[k])
            check($sformatf("done_at_settle_%0d", k), 32'(dn[k]), 32'(e0[k] | e1[k]));
         else
            check($sformatf("no_stray_done_%0d", k), 32'(dn[k]), 0);
         low_run[k] = (!e0[k] && !e1[k]) ? ((low_run[k] < 1000) ? low_run[k] + 1 : low_run[k]) : 0;
      end
      p0 = e0;
      p1 = e1;
   end

   assert property (@(posedge clk) !(bus_a.control_path_enable0 && bus_a.control_path_enable1))
      else $error("enables of dut_a high together");
   assert property (@(posedge clk) !(bus_b.control_path_enable0 && bus_b.control_path_enable1))
      else $error("enables of dut_b high together");

   initial begin
      // Power-up to path 0; adv counts edges since the previous row.
      vecs[0]  = '{"pwr_e2",   1'b1, 1'b0, 2, 5'b00000};
      vecs[1]  = '{"pwr_e3",   1'b1, 1'b0, 1, 5'b00010};
      vecs[2]  = '{"pwr_e6",   1'b1, 1'b0, 3, 5'b00010};
      vecs[3]  = '{"pwr_e7",   1'b1, 1'b0, 1, 5'b10010};
      vecs[4]  = '{"pwr_e9",   1'b1, 1'b0, 2, 5'b10001};
      vecs[5]  = '{"pwr_e10",  1'b1, 1'b0, 1, 5'b10000};
      // Switch path 0 -> 1.
      vecs[6]  = '{"sw1_e2",   1'b1, 1'b1, 2, 5'b10000};
      vecs[7]  = '{"sw1_e3",   1'b1, 1'b1, 1, 5'b00010};
      vecs[8]  = '{"sw1_e6",   1'b1, 1'b1, 3, 5'b00010};
      vecs[9]  = '{"sw1_e7",   1'b1, 1'b1, 1, 5'b01110};
      vecs[10] = '{"sw1_e9",   1'b1, 1'b1, 2, 5'b01101};
      vecs[11] = '{"sw1_e10",  1'b1, 1'b1, 1, 5'b01100};

      rst = 1'b1;
      bus_a.path_en = 1'b0; bus_a.path_sel = 1'b0;
      bus_b.path_en = 1'b0; bus_b.path_sel = 1'b0;
      step(3);
      check("reset_outs", outs_a(), 0);

      rst = 1'b0;
      run_range(0, 11);

      // Back to path 0.
      bus_a.path_sel = 1'b0;
      step(9);  check("back0_e9",  outs_a(), 32'(5'b10001));
      step(1);  check("back0_e10", outs_a(), 32'(5'b10000));

      // Select toggles during DRAIN are ignored; a 0 left during SETTLE re-runs.
      bus_a.path_sel = 1'b1;
      step(4);  check("tog_e4", outs_a(), 32'(5'b00010));
      bus_a.path_sel = 1'b0;
      step(1);
      bus_a.path_sel = 1'b1;
      step(2);  check("tog_e7", outs_a(), 32'(5'b01110));
      bus_a.path_sel = 1'b0;
      step(2);  check("tog_e9",  outs_a(), 32'(5'b01101));
      step(1);  check("tog_e10", outs_a(), 32'(5'b00110));
      step(4);  check("tog_e14", outs_a(), 32'(5'b10010));
      step(2);  check("tog_e16", outs_a(), 32'(5'b10001));

      // Drop path_en so the synchronized value falls mid-SETTLE.
      bus_a.path_sel = 1'b1;
      step(6);  check("abort_e6", outs_a(), 32'(5'b00010));
      bus_a.path_en = 1'b0;
      step(1);  check("abort_e7", outs_a(), 32'(5'b01110));
      step(1);  check("abort_e8", outs_a(), 32'(5'b01110));
      step(1);  check("abort_e9", outs_a(), 32'(5'b00100));
      step(3);  check("abort_idle", outs_a(), 32'(5'b00100));
      bus_a.path_en = 1'b1;
      step(3);  check("reen_e3", outs_a(), 32'(5'b00110));
      step(3);  check("reen_e6", outs_a(), 32'(5'b00110));
      step(1);  check("reen_e7", outs_a(), 32'(5'b01110));
      step(2);  check("reen_e9", outs_a(), 32'(5'b01101));
      step(1);

      // Reset in the middle of DRAIN, then a normal power-up.
      bus_a.path_sel = 1'b0;
      step(4);  check("rst_drain_pre", outs_a(), 32'(5'b00110));
      rst = 1'b1;
      step(1);  check("rst_drain", outs_a(), 0);
      rst = 1'b0;
      run_range(0, 5);

      // Reset while ON, then a normal power-up.
      rst = 1'b1;
      step(1);  check("rst_on", outs_a(), 0);
      rst = 1'b0;
      run_range(0, 5);

      // Random requests on the fast instance; the monitors do the checking.
      bus_b.path_en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0)  bus_b.path_sel = ~bus_b.path_sel;
         if ($urandom_range(0, 31) == 0) bus_b.path_en  = ~bus_b.path_en;
         step(1);
      end
      bus_b.path_en = 1'b1;
      step(20);
      check("rand_final",
            32'({bus_b.control_path_enable0, bus_b.control_path_enable1,
                 bus_b.active_path, bus_b.switch_busy}),
            32'({~bus_b.path_sel, bus_b.path_sel, bus_b.path_sel, 1'b0}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_route_path_sel_ctrl.md
Name: clock_route_path_sel_ctrl

Overview:
Sequencer that generates glitch-free enables control_path_enable0/1 for the downstream two-input clock route path mux.
It guarantees the two enables are never high together. It also guarantees a programmable dead time with both enables low before any enable rises.
It runs on an always-on reference clock and accepts asynchronous, level-type select and enable requests from software or power control.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer for path_en and path_sel (legal >= 2)
OFF_CYCLES, 4, dead-time cycles with both enables low before the new enable rises (legal >= 1)
ON_CYCLES, 2, settle cycles after the new enable rises before the switch is reported done (legal >= 1)

Ports:
clk  input  1  always-on reference clock
rst  input  1  synchronous, active-high reset
path_en  input  1  async level; 1 = a clock path is requested, 0 = both paths off
path_sel  input  1  async level; requested path, 0 = in0, 1 = in1
control_path_enable0  output  1  registered enable to mux gate 0
control_path_enable1  output  1  registered enable to mux gate 1
active_path  output  1  path currently or next enabled (registered)
switch_busy  output  1  1 while a sequence is in DRAIN or SETTLE
switch_done  output  1  single-cycle pulse when SETTLE completes

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. All outputs and state are registered.
- Reset values: enables 0/0, active_path 0, switch_busy 0, switch_done 0, state OFF, counter 0, synchronizers 0.
- Input synchronizers: path_en and path_sel each pass through a SYNC_STAGES flop chain. The FSM sees only the synchronized values, path_en_s and path_sel_s.
- Down-counter: width clog2(max(OFF_CYCLES, ON_CYCLES)+1). It is loaded with N-1 on state entry and the state exits when it reaches 0.
- FSM states:
  - OFF: both enables 0, busy 0. If path_en_s=1, then tgt <= path_sel_s, cnt <= OFF_CYCLES-1, go to DRAIN.
  - DRAIN: both enables 0, busy 1. When cnt==0, raise enable[tgt], set active_path <= tgt, cnt <= ON_CYCLES-1, go to SETTLE. Otherwise decrement.
  - SETTLE: only enable[tgt] high, busy 1. When cnt==0, pulse switch_done for 1 cycle and go to ON. Otherwise decrement.
  - ON: only enable[active_path] high, busy 0. If path_sel_s != active_path, drop both enables, tgt <= path_sel_s, cnt <= OFF_CYCLES-1, go to DRAIN.
- Priority: path_en_s=0 in any state forces OFF at the next edge, with both enables 0 and busy 0. This applies mid-DRAIN and mid-SETTLE; no switch_done pulse is issued in that case.
- Select changes: path_sel_s changes during DRAIN or SETTLE are ignored. tgt is latched at DRAIN entry. After reaching ON, the current path_sel_s is re-evaluated, so the last value wins, each switch runs a full sequence, and no request is lost.
- Entering from OFF always passes through DRAIN, so the dead time is also enforced after a power-off and after reset.
- Invariant: control_path_enable0 & control_path_enable1 == 0 on every cycle. Any enable rising edge is preceded by >= OFF_CYCLES consecutive cycles with both enables low.
- Reset mid-operation: outputs return to reset values at the reset edge, regardless of state.
- Latency with defaults: a raw change settles before edge 1. The synchronized value is visible after edge 2. The FSM acts at edge 3. The new enable is high after edge 7. switch_done is high and busy low after edge 9.

Test Plan:
- Reset, then path_en=1, path_sel=0 -> busy after edge 3; enable0=1 after edge 7; switch_done one cycle after edge 9; enable1 stays 0 throughout.
- In ON with path 0, toggle path_sel to 1 -> enable0 low after edge 3; enable1 high after edge 7 (4-cycle gap); active_path=1; one done pulse.
- In DRAIN, toggle path_sel 1->0->1 -> sequence completes to path 1. A final path_sel=0 left during SETTLE triggers a second full sequence after ON is reached.
- Deassert path_en mid-SETTLE -> both enables 0 the cycle after path_en_s falls; busy 0; no done pulse. Reassert -> full OFF_CYCLES gap before the enable rises.
- Assert rst mid-DRAIN and mid-ON -> all outputs reach reset values at the next edge. Release with path_en=1 -> normal power-up sequence.
- Random path_en/path_sel with OFF_CYCLES=1, ON_CYCLES=1 and with SYNC_STAGES=3 -> assertion that the enables are never both high, a dead-time check, and exactly one done pulse per completed switch.
